// File: rtl/ofm_packer.sv
// OFM element packer: gathers DATA_WIDTH elements into BYTES_PER_WORD-lane words
// and queues them in a small first-word-fall-through FIFO toward a ready/valid sink.
module ofm_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 ofm_valid,
  input  logic signed [DATA_WIDTH-1:0]         ofm_input,
  input  logic                                 layer_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] out_data,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 overflow,
  output logic [COUNT_WIDTH-1:0]               word_count
);

  localparam int WW = DATA_WIDTH * BYTES_PER_WORD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_t;

  state_t        state, state_next;
  logic [LW-1:0] lane;
  logic [WW-1:0] pack_reg;
  logic [WW-1:0] word_next;
  logic [WW:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full;
  logic          pop, take, complete, push, drain_exit;
  logic [WW:0]   head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = mem[rd_ptr[AW-1:0]];

  // Head is gated so the word bus reads zero whenever nothing is queued.
  assign out_valid  = !fifo_empty;
  assign out_data   = out_valid ? head[WW-1:0] : '0;
  assign out_last   = out_valid & head[WW];

  assign pop        = out_valid & out_ready;
  assign take       = (state == PACK) & ofm_valid & ~start;
  assign complete   = take & ((lane == LW'(BYTES_PER_WORD - 1)) | layer_last);
  assign push       = complete & (~fifo_full | pop);
  // A dropped last word leaves nothing to hand off, so an empty FIFO also ends the layer.
  assign drain_exit = (state == DRAIN) & (fifo_empty | (pop & out_last));

  always_comb begin
    word_next = pack_reg;
    word_next[int'(lane)*DATA_WIDTH +: DATA_WIDTH] = ofm_input;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = PACK;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        PACK:    if (take && layer_last) state_next = DRAIN;
        DRAIN:   if (drain_exit) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
    done = drain_exit & ~start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane       <= '0;
      pack_reg   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else if (start) begin
      lane       <= '0;
      pack_reg   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (take) begin
        if (complete) begin
          lane     <= '0;
          pack_reg <= '0;
        end else begin
          lane     <= lane + LW'(1);
          pack_reg <= word_next;
        end
      end
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + (AW+1)'(1);
        word_count <= word_count + COUNT_WIDTH'(1);
      end
      if (complete && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {layer_last, word_next};
  end

endmodule

// File: tb/tb_ofm_packer.sv
// Scoreboard bench for ofm_packer: stimulus queues expected words, a monitor
// pops and compares on every output handshake and checks stall stability.
module tb_ofm_packer;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              ofm_valid;
  logic signed [7:0] ofm_input;
  logic              layer_last;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [15:0]       word_count;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [32:0] sb[$];
  logic        stall_prev = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  ofm_packer #(
    .DATA_WIDTH(8),
    .BYTES_PER_WORD(4),
    .FIFO_DEPTH(4),
    .COUNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .ofm_valid(ofm_valid),
    .ofm_input(ofm_input),
    .layer_last(layer_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .busy(busy),
    .done(done),
    .overflow(overflow),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change #1 after posedge, so negedge sees the values used at the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!out_valid || out_data !== prev_data || out_last !== prev_last) begin
          errors++;
          $display("FAIL stall_stable: got v=%0b d=%h l=%0b expected v=1 d=%h l=%0b",
                   out_valid, out_data, out_last, prev_data, prev_last);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got d=%h l=%0b expected no word", out_data, out_last);
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          if ({out_last, out_data} !== e) begin
            errors++;
            $display("FAIL word: got d=%h l=%0b expected d=%h l=%0b",
                     out_data, out_last, e[31:0], e[32]);
          end
        end
      end
      if (done) done_cnt++;
      stall_prev = out_valid && !out_ready && !start;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    ofm_valid  = 1'b1;
    ofm_input  = d;
    layer_last = last;
    step();
    ofm_valid  = 1'b0;
    layer_last = 1'b0;
  endtask

  // Element value base+i; word w holds elements base+4w .. base+4w+3, lowest in LSBs.
  task automatic send_words(input int n, input logic [7:0] base, input logic last_end,
                            input logic expect_out);
    for (int w = 0; w < n; w++) begin
      logic [7:0] b;
      logic       l;
      b = base + 8'(4 * w);
      l = last_end && (w == n - 1);
      if (expect_out) sb.push_back({l, b + 8'd3, b + 8'd2, b + 8'd1, b});
      for (int k = 0; k < 4; k++) send(b + 8'(k), l && (k == 3));
    end
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; ofm_valid = 1'b0; ofm_input = '0;
    layer_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_word_count", word_count, 0);
    rst_n = 1'b1;
    step();

    // Elements in IDLE are ignored
    out_ready = 1'b1;
    send(8'hAA, 1'b0); send(8'hBB, 1'b1);
    step();
    check("idle_ignore_valid", out_valid, 0);

    // Basic four-element word
    do_start();
    check("start_busy", busy, 1);
    sb.push_back({1'b0, 32'h04030201});
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
    check("t1_not_yet_valid", out_valid, 0);
    send(8'h04, 1'b0);
    check("t1_valid_latency", out_valid, 1);
    check("t1_data", out_data, 32'h04030201);
    step();
    check("t1_word_count", word_count, 1);

    // Short final word with zero fill and done pulse
    do_start();
    check("t2_wc_cleared", word_count, 0);
    sb.push_back({1'b1, 32'h00332211});
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b1);
    check("t2_data", out_data, 32'h00332211);
    check("t2_last", out_last, 1);
    check("t2_done", done, 1);
    check("t2_drain_busy", busy, 1);
    step();
    check("t2_idle", busy, 0);
    check("t2_done_pulse", done, 0);
    check("t2_word_count", word_count, 1);

    // Overflow: five words against a stalled sink
    out_ready = 1'b0;
    do_start();
    sb.push_back({1'b0, 32'h04030201});
    sb.push_back({1'b0, 32'h08070605});
    sb.push_back({1'b0, 32'h0C0B0A09});
    sb.push_back({1'b0, 32'h100F0E0D});
    for (int i = 1; i <= 16; i++) send(8'(i), 1'b0);
    check("t3_no_overflow_yet", overflow, 0);
    for (int i = 17; i <= 20; i++) send(8'(i), 1'b0);
    check("t3_overflow", overflow, 1);
    out_ready = 1'b1;
    repeat (8) step();
    check("t3_word_count", word_count, 4);
    check("t3_drained", out_valid, 0);
    check("t3_overflow_sticky", overflow, 1);

    // Full FIFO with simultaneous pop accepts the completing word
    out_ready = 1'b0;
    do_start();
    check("t4_overflow_cleared", overflow, 0);
    send_words(4, 8'h20, 1'b0, 1'b1);
    sb.push_back({1'b0, 32'h33323130});
    send(8'h30, 1'b0); send(8'h31, 1'b0); send(8'h32, 1'b0);
    out_ready = 1'b1;
    send(8'h33, 1'b0);
    check("t4_no_overflow", overflow, 0);
    repeat (6) step();
    check("t4_word_count", word_count, 5);

    // Toggling ready across eight words ending the layer
    d0 = done_cnt;
    do_start();
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          out_ready = ~out_ready;
          step();
        end
        out_ready = 1'b1;
      end
      send_words(8, 8'h40, 1'b1, 1'b1);
    join
    for (int i = 0; i < 50 && busy; i++) step();
    check("t5_idle", busy, 0);
    check("t5_word_count", word_count, 8);
    check("t5_done_once", done_cnt - d0, 1);
    check("t5_no_overflow", overflow, 0);

    // Restart mid-layer discards buffered words, then reset mid-layer
    d0 = done_cnt;
    out_ready = 1'b1;
    do_start();
    send_words(1, 8'h60, 1'b0, 1'b1);
    step();
    out_ready = 1'b0;
    send_words(2, 8'h70, 1'b0, 1'b0);
    check("t6_buffered", out_valid, 1);
    check("t6_wc_before", word_count, 1);
    do_start();
    check("t6_flushed", out_valid, 0);
    check("t6_wc_cleared", word_count, 0);
    check("t6_busy", busy, 1);
    out_ready = 1'b1;
    send_words(1, 8'h80, 1'b0, 1'b1);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(8'(8'h90 + i), 1'b0);
    check("t6_pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #2;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_wc", word_count, 0);
    check("t6_rst_data", out_data, 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(8'(8'hA0 + i), 1'b0);
    repeat (3) step();
    check("t6_post_valid", out_valid, 0);
    check("t6_post_busy", busy, 0);
    check("t6_no_done", done_cnt - d0, 0);
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
